// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequence controller: controller
// state encoding and the default datapath widths.
package fib_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_IDX_WIDTH  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } fib_state_t;

endpackage

// File: rtl/fib_seq_ctrl_step.sv
// Term-pair register for the Fibonacci datapath. It holds the two most recent
// terms and exposes the carry-out of their sum, so the controller can track
// overflow without needing to know the datapath width.
module fib_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    output logic [DATA_WIDTH-1:0] prev,
    output logic [DATA_WIDTH-1:0] curr,
    output logic                  carry
);

    logic [DATA_WIDTH:0] sum_full;

    assign sum_full = {1'b0, curr} + {1'b0, prev};
    assign carry    = sum_full[DATA_WIDTH];

    // Reset clears the pair, load seeds it with (0, 1), step advances one term,
    // and any other cycle holds the pair unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '0;
            curr <= '0;
        end else if (load) begin
            prev <= '0;
            curr <= DATA_WIDTH'(1);
        end else if (step) begin
            prev <= curr;
            curr <= sum_full[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fib_seq_ctrl.sv
// Fibonacci term controller. A request for term n is accepted in IDLE. RUN then
// performs n additions, and RESP presents F(n) together with a sticky overflow
// flag until the consumer takes it. Abort or reset drops the transaction
// silently.
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IDX_WIDTH  = DEFAULT_IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [IDX_WIDTH-1:0]  req_idx,
    output logic                  req_ready,
    input  logic                  abort,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_ovf,
    output logic                  busy
);

    fib_state_t             state;
    logic [IDX_WIDTH-1:0]   count;
    logic                   ovf;
    logic                   load;
    logic                   step;
    logic [DATA_WIDTH-1:0]  prev;
    logic [DATA_WIDTH-1:0]  curr;
    logic                   carry;

    assign load = (state == IDLE) && req_valid;
    assign step = (state == RUN) && !abort && (count != '0);

    fib_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .prev  (prev),
        .curr  (curr),
        .carry (carry)
    );

    // Controller sequencing. Reset wins over everything, and abort only matters
    // while a transaction is in flight. A retiring response always returns to
    // IDLE first, so a new request cannot be accepted on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        count <= req_idx;
                        ovf   <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (count != '0) begin
                        count <= count - IDX_WIDTH'(1);
                        ovf   <= ovf | carry;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (abort || resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);
    assign resp_data  = resp_valid ? curr : '0;
    assign resp_ovf   = resp_valid & ovf;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl. A 32-bit instance and an 8-bit instance
// share their stimulus, so the same vectors cover the wrapped-term case.
module tb_fib_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [5:0]  req_idx;
    logic        abort;
    logic        resp_ready;

    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_ovf;
    logic        busy;

    logic        req_ready8;
    logic        resp_valid8;
    logic [7:0]  resp_data8;
    logic        resp_ovf8;
    logic        busy8;

    int total = 0;
    int bad   = 0;

    fib_seq_ctrl #(.DATA_WIDTH(32), .IDX_WIDTH(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_idx    (req_idx),
        .req_ready  (req_ready),
        .abort      (abort),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    fib_seq_ctrl #(.DATA_WIDTH(8), .IDX_WIDTH(6)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_idx    (req_idx),
        .req_ready  (req_ready8),
        .abort      (abort),
        .resp_valid (resp_valid8),
        .resp_ready (resp_ready),
        .resp_data  (resp_data8),
        .resp_ovf   (resp_ovf8),
        .busy       (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [5:0] idx);
        req_idx   = idx;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Counts edges until resp_valid rises, giving up after the limit.
    task automatic wait_resp(input int limit, output int edges);
        edges = 0;
        while (!resp_valid && edges < limit) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_req_ready got=%0b want=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_resp_valid got=%0b want=0", resp_valid); end
        total++; if (resp_data !== 32'd0) begin bad++; $display("[TB] FAIL rst_resp_data got=%0d want=0", resp_data); end
        total++; if (resp_ovf !== 1'b0) begin bad++; $display("[TB] FAIL rst_resp_ovf got=%0b want=0", resp_ovf); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%0b want=0", busy); end
        // A request that arrives while reset is high must be ignored.
        req_valid = 1'b1;
        req_idx   = 6'd3;
        tick();
        req_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_prio_busy got=%0b want=0", busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_short_terms();
        int edges;
        resp_ready = 1'b1;
        accept(6'd0);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL idx0_busy got=%0b want=1", busy); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL idx0_req_ready got=%0b want=0", req_ready); end
        wait_resp(100, edges);
        total++; if (edges != 1) begin bad++; $display("[TB] FAIL idx0_latency got=%0d want=1", edges); end
        total++; if (resp_data !== 32'd1) begin bad++; $display("[TB] FAIL idx0_data got=%0d want=1", resp_data); end
        total++; if (resp_ovf !== 1'b0) begin bad++; $display("[TB] FAIL idx0_ovf got=%0b want=0", resp_ovf); end
        tick();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL idx0_retire got=%0b want=0", resp_valid); end
        total++; if (resp_data !== 32'd0) begin bad++; $display("[TB] FAIL idx0_data_gated got=%0d want=0", resp_data); end
        tick();

        accept(6'd1);
        wait_resp(100, edges);
        total++; if (edges != 2) begin bad++; $display("[TB] FAIL idx1_latency got=%0d want=2", edges); end
        total++; if (resp_data !== 32'd1) begin bad++; $display("[TB] FAIL idx1_data got=%0d want=1", resp_data); end
        tick();
        tick();

        accept(6'd10);
        wait_resp(100, edges);
        total++; if (edges != 11) begin bad++; $display("[TB] FAIL idx10_latency got=%0d want=11", edges); end
        total++; if (resp_data !== 32'd89) begin bad++; $display("[TB] FAIL idx10_data got=%0d want=89", resp_data); end
        total++; if (resp_ovf !== 1'b0) begin bad++; $display("[TB] FAIL idx10_ovf got=%0b want=0", resp_ovf); end
        total++; if (resp_data8 !== 8'd89) begin bad++; $display("[TB] FAIL idx10_data8 got=%0d want=89", resp_data8); end
        tick();
        tick();
    endtask

    task automatic test_overflow();
        int edges;
        resp_ready = 1'b1;
        accept(6'd12);
        wait_resp(100, edges);
        total++; if (resp_data8 !== 8'd233) begin bad++; $display("[TB] FAIL idx12_data8 got=%0d want=233", resp_data8); end
        total++; if (resp_ovf8 !== 1'b0) begin bad++; $display("[TB] FAIL idx12_ovf8 got=%0b want=0", resp_ovf8); end
        tick();
        tick();

        accept(6'd13);
        wait_resp(100, edges);
        total++; if (edges != 14) begin bad++; $display("[TB] FAIL idx13_latency got=%0d want=14", edges); end
        total++; if (resp_valid8 !== 1'b1) begin bad++; $display("[TB] FAIL idx13_valid8 got=%0b want=1", resp_valid8); end
        total++; if (resp_data8 !== 8'd121) begin bad++; $display("[TB] FAIL idx13_data8 got=%0d want=121", resp_data8); end
        total++; if (resp_ovf8 !== 1'b1) begin bad++; $display("[TB] FAIL idx13_ovf8 got=%0b want=1", resp_ovf8); end
        total++; if (resp_data !== 32'd377) begin bad++; $display("[TB] FAIL idx13_data32 got=%0d want=377", resp_data); end
        total++; if (resp_ovf !== 1'b0) begin bad++; $display("[TB] FAIL idx13_ovf32 got=%0b want=0", resp_ovf); end
        tick();
        tick();

        accept(6'd2);
        wait_resp(100, edges);
        total++; if (resp_data8 !== 8'd2) begin bad++; $display("[TB] FAIL idx2_data8 got=%0d want=2", resp_data8); end
        total++; if (resp_ovf8 !== 1'b0) begin bad++; $display("[TB] FAIL idx2_ovf8_cleared got=%0b want=0", resp_ovf8); end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        int edges;
        resp_ready = 1'b0;
        accept(6'd5);
        wait_resp(100, edges);
        total++; if (edges != 6) begin bad++; $display("[TB] FAIL hold_latency got=%0d want=6", edges); end
        // Offer a competing request while the response is being held.
        req_valid = 1'b1;
        req_idx   = 6'd9;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_valid cyc=%0d got=%0b want=1", i, resp_valid); end
            total++; if (resp_data !== 32'd8) begin bad++; $display("[TB] FAIL hold_data cyc=%0d got=%0d want=8", i, resp_data); end
            total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_req_ready cyc=%0d got=%0b want=0", i, req_ready); end
        end
        // Retire with req_valid still high: no same-edge accept allowed.
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL retire_valid got=%0b want=0", resp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL retire_no_accept got=%0b want=0", busy); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL retire_req_ready got=%0b want=1", req_ready); end
        tick();
    endtask

    task automatic test_abort();
        int edges;
        int seen;
        resp_ready = 1'b1;
        accept(6'd20);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%0b want=0", busy); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_req_ready got=%0b want=1", req_ready); end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL abort_no_resp got=%0d want=0", seen); end
        // Abort held high in IDLE must not block acceptance.
        abort = 1'b1;
        accept(6'd3);
        abort = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_idle_accept got=%0b want=1", busy); end
        wait_resp(100, edges);
        total++; if (edges != 4) begin bad++; $display("[TB] FAIL post_abort_latency got=%0d want=4", edges); end
        total++; if (resp_data !== 32'd3) begin bad++; $display("[TB] FAIL post_abort_data got=%0d want=3", resp_data); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_run();
        int edges;
        int seen;
        resp_ready = 1'b1;
        accept(6'd20);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%0b want=0", busy); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_req_ready got=%0b want=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got=%0b want=0", resp_valid); end
        total++; if (resp_data !== 32'd0) begin bad++; $display("[TB] FAIL midrst_data got=%0d want=0", resp_data); end
        total++; if (resp_ovf !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ovf got=%0b want=0", resp_ovf); end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (resp_valid || busy) seen++;
            tick();
        end
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL midrst_quiet got=%0d want=0", seen); end

        // Reset while a response is being held also drops it.
        resp_ready = 1'b0;
        accept(6'd4);
        wait_resp(100, edges);
        total++; if (resp_data !== 32'd5) begin bad++; $display("[TB] FAIL resprst_data got=%0d want=5", resp_data); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL resprst_valid got=%0b want=0", resp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL resprst_busy got=%0b want=0", busy); end
        resp_ready = 1'b1;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_idx    = '0;
        abort      = 1'b0;
        resp_ready = 1'b0;
        test_reset();
        test_short_terms();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fib_seq_ctrl.md
FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the Fibonacci term and of resp_data.
REQ-002 SHALL have parameter IDX_WIDTH, default 6, width of the requested term index.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1, a request for term F(req_idx) is present.
REQ-006 SHALL have port req_idx, input, IDX_WIDTH, index n of the requested term.
REQ-007 SHALL have port req_ready, output, 1, the controller can accept a request.
REQ-008 SHALL have port abort, input, 1, cancels any request in flight.
REQ-009 SHALL have port resp_valid, output, 1, resp_data and resp_ovf are valid.
REQ-010 SHALL have port resp_ready, input, 1, the consumer accepts the response.
REQ-011 SHALL have port resp_data, output, DATA_WIDTH, F(n) modulo 2^DATA_WIDTH.
REQ-012 SHALL have port resp_ovf, output, 1, at least one step of the sequence to F(n) carried out of DATA_WIDTH.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 Sequence SHALL be F(0)=1, F(1)=1, F(n)=F(n-1)+F(n-2).
REQ-015 FSM SHALL have exactly three states: IDLE, RUN, RESP.
REQ-016 req_ready SHALL equal (state==IDLE); a request is accepted on a rising edge where req_valid and req_ready are both high.
REQ-017 On acceptance: prev<=0, curr<=1, count<=req_idx, ovf<=0, state<=RUN; req_idx is sampled only at acceptance.
REQ-018 In RUN with count!=0 and abort low: curr<=curr+prev (truncated to DATA_WIDTH), prev<=curr, count<=count-1, ovf<=ovf OR carry-out.
REQ-019 In RUN with count==0 and abort low: state<=RESP; curr, prev and ovf hold.
REQ-020 resp_valid SHALL go high n+1 rising edges after the accepting edge, so n=0 gives 1 edge of latency.
REQ-021 resp_valid SHALL equal (state==RESP); resp_data SHALL equal curr and resp_ovf SHALL equal ovf, both stable while resp_valid is high.
REQ-022 In RESP, the edge with resp_ready high SHALL move the state to IDLE; with resp_ready low the state and data SHALL hold indefinitely.
REQ-023 There SHALL be no same-edge response-retire and new-accept; at least one IDLE cycle separates transactions.
REQ-024 abort high in RUN or RESP SHALL move the state to IDLE on that edge with no response; abort in IDLE SHALL have no effect.
REQ-025 Once ovf is set it SHALL stay set until the next acceptance; a wrapped resp_data SHALL still be delivered.
REQ-026 resp_data and resp_ovf SHALL be 0 whenever resp_valid is low.

Reset
REQ-027 reset SHALL take priority over abort and all handshakes on the same edge.
REQ-028 On reset: state=IDLE, prev=0, curr=0, count=0, ovf=0, which gives req_ready=1, resp_valid=0, resp_data=0, resp_ovf=0, busy=0.
REQ-029 reset asserted mid-RUN or in RESP SHALL discard the transaction with no response produced.

Structure
REQ-030 Package fib_pkg SHALL hold the state enum (IDLE, RUN, RESP) and the default width constants.
REQ-031 The prev/curr register pair with its adder and carry-out SHALL be a sub-module fib_step (load, step, hold controls); fib_seq_ctrl holds the FSM, counter and ovf flag.

Verification
REQ-032 idx=0, resp_ready=1 -> resp_valid 1 edge after accept, resp_data=1, resp_ovf=0.
REQ-033 idx=1 -> resp_data=1; idx=10 -> resp_data=89 after 11 edges, resp_ovf=0.
REQ-034 DATA_WIDTH=8: idx=12 -> resp_data=233, ovf=0; idx=13 -> resp_data=121, ovf=1; next idx=2 -> resp_data=2, ovf=0.
REQ-035 idx=5 with resp_ready low for 6 cycles -> resp_data=8 held stable; req_ready stays 0; IDLE entered on the edge where resp_ready=1.
REQ-036 idx=20, abort at 3rd RUN cycle -> IDLE next edge, no resp_valid; a following idx=3 request -> resp_data=3.
REQ-037 idx=20, reset at 4th RUN cycle -> all outputs at their reset values next edge; no resp_valid until a new request.
